// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - timing types, display presets and total helper
package video_pkg;

  typedef struct packed {
    int   active;
    int   fp;
    int   sync;
    int   bp;
    logic pol;
  } vt_axis_t;

  typedef struct packed {
    vt_axis_t h;
    vt_axis_t v;
  } vt_t;

  localparam vt_t VT_640x480_60 = '{
    h: '{active: 640, fp: 16, sync: 96, bp: 48, pol: 1'b0},
    v: '{active: 480, fp: 10, sync: 2, bp: 33, pol: 1'b0}
  };

  // 74.25 MHz pixel clock
  localparam vt_t VT_1280x720_60 = '{
    h: '{active: 1280, fp: 110, sync: 40, bp: 220, pol: 1'b1},
    v: '{active: 720, fp: 5, sync: 5, bp: 20, pol: 1'b1}
  };

  function automatic int axis_total(vt_axis_t a);
    return a.active + a.fp + a.sync + a.bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_axis_counter.sv
// rtl/video_timing_gen_axis_counter.sv - one raster axis: counter, wrap flag, next-position decode
module axis_counter
  import video_pkg::*;
#(
  parameter int CORDW  = 10,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             step,
  output logic [CORDW-1:0] pos,
  output logic             last,
  output logic             next_active,
  output logic             next_sync
);

  localparam vt_axis_t CFG = '{active: ACTIVE, fp: FP, sync: SYNC, bp: BP, pol: 1'b0};
  localparam int TOTAL = axis_total(CFG);

  // One spare bit so parameter sums cannot wrap inside the comparisons.
  localparam logic [CORDW:0] LAST_W   = (CORDW+1)'(TOTAL - 1);
  localparam logic [CORDW:0] ACT_END  = (CORDW+1)'(ACTIVE);
  localparam logic [CORDW:0] SYNC_BEG = (CORDW+1)'(ACTIVE + FP);
  localparam logic [CORDW:0] SYNC_END = (CORDW+1)'(ACTIVE + FP + SYNC);

  if (BP < 1) begin : g_bp_check
    $error("axis_counter: back porch must be at least 1");
  end
  if ((1 << CORDW) < TOTAL) begin : g_cordw_check
    $error("axis_counter: CORDW too small for axis total");
  end

  logic [CORDW:0] pos_w;
  logic [CORDW:0] next_w;

  assign pos_w = {1'b0, pos};
  assign last  = (pos_w == LAST_W);

  // Position this axis will hold after the next enabled pixel.
  always_comb begin
    next_w = pos_w;
    if (step) begin
      next_w = last ? '0 : pos_w + 1'b1;
    end
  end

  assign next_active = (next_w < ACT_END);
  assign next_sync   = (next_w >= SYNC_BEG) && (next_w < SYNC_END);

  // Counter starts on the last position so the first enabled pixel is 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= LAST_W[CORDW-1:0];
    end else if (en) begin
      pos <= next_w[CORDW-1:0];
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised raster timing generator with pixel enable
module video_timing_gen
  import video_pkg::*;
#(
  parameter int CORDW    = 10,
  parameter int H_ACTIVE = VT_640x480_60.h.active,
  parameter int H_FP     = VT_640x480_60.h.fp,
  parameter int H_SYNC   = VT_640x480_60.h.sync,
  parameter int H_BP     = VT_640x480_60.h.bp,
  parameter int V_ACTIVE = VT_640x480_60.v.active,
  parameter int V_FP     = VT_640x480_60.v.fp,
  parameter int V_SYNC   = VT_640x480_60.v.sync,
  parameter int V_BP     = VT_640x480_60.v.bp,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  output logic [CORDW-1:0] sx_out,
  output logic [CORDW-1:0] sy_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             de_out,
  output logic             line_out,
  output logic             frame_out
);

  localparam logic HP = (H_POL != 0);
  localparam logic VP = (V_POL != 0);

  logic h_last, h_active, h_sync;
  logic v_last, v_active, v_sync;

  axis_counter #(
    .CORDW(CORDW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk        (clk_in),
    .rst        (rst_in),
    .en         (en_in),
    .step       (1'b1),
    .pos        (sx_out),
    .last       (h_last),
    .next_active(h_active),
    .next_sync  (h_sync)
  );

  // Vertical axis steps only on horizontal wrap, so vsync flips at sx=0.
  axis_counter #(
    .CORDW(CORDW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk        (clk_in),
    .rst        (rst_in),
    .en         (en_in),
    .step       (h_last),
    .pos        (sy_out),
    .last       (v_last),
    .next_active(v_active),
    .next_sync  (v_sync)
  );

  // Decoded signals registered from the next position, aligned with sx/sy.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hsync_out <= ~HP;
      vsync_out <= ~VP;
      de_out    <= 1'b0;
      line_out  <= 1'b0;
      frame_out <= 1'b0;
    end else if (en_in) begin
      hsync_out <= h_sync ? HP : ~HP;
      vsync_out <= v_sync ? VP : ~VP;
      de_out    <= h_active && v_active;
      line_out  <= h_last;
      frame_out <= h_last && v_last;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized bench with arithmetic raster model for video_timing_gen
module tb_video_timing_gen;
  import video_pkg::*;

  typedef struct packed {
    int ha, hf, hs, hb, va, vf, vs, vb, hp, vp;
  } tm_t;

  typedef struct packed {
    int   sx;
    int   sy;
    logic de, hs, vs, ln, fr;
  } obs_t;

  localparam tm_t TA = '{4, 1, 2, 1, 3, 1, 1, 1, 1, 1};
  localparam tm_t TB = '{20, 3, 5, 4, 10, 2, 2, 3, 0, 0};
  localparam tm_t TC = '{1280, 110, 40, 220, 720, 5, 5, 20, 1, 1};
  localparam tm_t TD = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  a_sx, a_sy;
  logic [5:0]  b_sx, b_sy;
  logic [10:0] c_sx, c_sy;
  logic [9:0]  d_sx, d_sy;
  logic a_hs, a_vs, a_de, a_ln, a_fr;
  logic b_hs, b_vs, b_de, b_ln, b_fr;
  logic c_hs, c_vs, c_de, c_ln, c_fr;
  logic d_hs, d_vs, d_de, d_ln, d_fr;

  video_timing_gen #(
    .CORDW(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1)
  ) dut_a (
    .clk_in(clk), .rst_in(rst), .en_in(en), .sx_out(a_sx), .sy_out(a_sy),
    .hsync_out(a_hs), .vsync_out(a_vs), .de_out(a_de), .line_out(a_ln), .frame_out(a_fr)
  );

  video_timing_gen #(
    .CORDW(6), .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .H_POL(0), .V_POL(0)
  ) dut_b (
    .clk_in(clk), .rst_in(rst), .en_in(en), .sx_out(b_sx), .sy_out(b_sy),
    .hsync_out(b_hs), .vsync_out(b_vs), .de_out(b_de), .line_out(b_ln), .frame_out(b_fr)
  );

  video_timing_gen #(
    .CORDW(11),
    .H_ACTIVE(VT_1280x720_60.h.active), .H_FP(VT_1280x720_60.h.fp),
    .H_SYNC(VT_1280x720_60.h.sync), .H_BP(VT_1280x720_60.h.bp),
    .V_ACTIVE(VT_1280x720_60.v.active), .V_FP(VT_1280x720_60.v.fp),
    .V_SYNC(VT_1280x720_60.v.sync), .V_BP(VT_1280x720_60.v.bp),
    .H_POL(int'(VT_1280x720_60.h.pol)), .V_POL(int'(VT_1280x720_60.v.pol))
  ) dut_c (
    .clk_in(clk), .rst_in(rst), .en_in(en), .sx_out(c_sx), .sy_out(c_sy),
    .hsync_out(c_hs), .vsync_out(c_vs), .de_out(c_de), .line_out(c_ln), .frame_out(c_fr)
  );

  video_timing_gen dut_d (
    .clk_in(clk), .rst_in(rst), .en_in(en), .sx_out(d_sx), .sy_out(d_sy),
    .hsync_out(d_hs), .vsync_out(d_vs), .de_out(d_de), .line_out(d_ln), .frame_out(d_fr)
  );

  // Number of enabled pixels since reset; the model is a pure function of it.
  int n;
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else if (en) n <= n + 1;
  end

  int tests = 0;
  int fails = 0;

  function automatic obs_t model(tm_t t, int k);
    obs_t o;
    int ht, vt, p, hb, vb;
    ht = t.ha + t.hf + t.hs + t.hb;
    vt = t.va + t.vf + t.vs + t.vb;
    if (k == 0) begin
      o.sx = ht - 1;
      o.sy = vt - 1;
      o.de = 1'b0;
      o.hs = (t.hp == 0);
      o.vs = (t.vp == 0);
      o.ln = 1'b0;
      o.fr = 1'b0;
    end else begin
      p    = (k - 1) % (ht * vt);
      o.sx = p % ht;
      o.sy = p / ht;
      hb   = t.ha + t.hf;
      vb   = t.va + t.vf;
      o.de = (o.sx < t.ha) && (o.sy < t.va);
      o.hs = (o.sx >= hb && o.sx < hb + t.hs) ? (t.hp != 0) : (t.hp == 0);
      o.vs = (o.sy >= vb && o.sy < vb + t.vs) ? (t.vp != 0) : (t.vp == 0);
      o.ln = (o.sx == 0);
      o.fr = (p == 0);
    end
    return o;
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s n=%0d got sx=%0d sy=%0d de=%b hs=%b vs=%b ln=%b fr=%b want sx=%0d sy=%0d de=%b hs=%b vs=%b ln=%b fr=%b",
               name, n, act.sx, act.sy, act.de, act.hs, act.vs, act.ln, act.fr,
               exp.sx, exp.sy, exp.de, exp.hs, exp.vs, exp.ln, exp.fr);
    end
  endtask

  function automatic obs_t obs_a();
    return '{sx: int'(a_sx), sy: int'(a_sy), de: a_de, hs: a_hs, vs: a_vs, ln: a_ln, fr: a_fr};
  endfunction
  function automatic obs_t obs_b();
    return '{sx: int'(b_sx), sy: int'(b_sy), de: b_de, hs: b_hs, vs: b_vs, ln: b_ln, fr: b_fr};
  endfunction
  function automatic obs_t obs_c();
    return '{sx: int'(c_sx), sy: int'(c_sy), de: c_de, hs: c_hs, vs: c_vs, ln: c_ln, fr: c_fr};
  endfunction
  function automatic obs_t obs_d();
    return '{sx: int'(d_sx), sy: int'(d_sy), de: d_de, hs: d_hs, vs: d_vs, ln: d_ln, fr: d_fr};
  endfunction

  task automatic compare_all();
    check("tiny", obs_a(), model(TA, n));
    check("mid", obs_b(), model(TB, n));
    check("720p", obs_c(), model(TC, n));
    check("vga", obs_d(), model(TD, n));
  endtask

  // mode 0: always enabled, 1: repeating 1-0-0-1, 2: random ~75% enabled
  task automatic run(int cycles, int mode);
    for (int i = 0; i < cycles; i++) begin
      case (mode)
        0:       en = 1'b1;
        1:       en = ((i % 4) == 0) || ((i % 4) == 3);
        default: en = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      compare_all();
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    run(4, 2);
    rst = 1'b0;

    run(1, 0);
    check("tiny_first", obs_a(), '{0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    check("mid_first", obs_b(), '{0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
    run(47, 0);
    check("tiny_last_pixel", obs_a(), '{7, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("model_tiny_last", model(TA, n), '{7, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    run(1, 0);
    check("tiny_wrap", obs_a(), '{0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    check("mid_n49", obs_b(), '{16, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});

    run(200, 0);
    run(400, 1);
    run(3000, 2);

    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_async_rst", obs_b(), '{31, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    check("tiny_async_rst", obs_a(), '{7, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    #1;
    run(2, 2);
    rst = 1'b0;

    run(1391, 0);
    check("720p_hsync_start", obs_c(), '{1390, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    check("tiny_n1391", obs_a(), '{6, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    check("vga_n1391", obs_d(), '{590, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    run(600, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator; next generation of the fixed 640x480p60 screen counter.
- Timing parameters are set per instance, sync polarity is selectable, and a pixel-clock enable input allows running from a faster system clock.
- All outputs are registered and mutually aligned; one-cycle line-start and frame-start strobes are added.
- Sits between the clock/reset block and the raycaster pixel pipeline and the display encoder.

Parameters:
- CORDW, 10, width of sx_out/sy_out; must satisfy 2^CORDW >= max(H_TOTAL, V_TOTAL).
- H_ACTIVE, 640, active pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels); must be >= 1.
- V_ACTIVE, 480, active lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines); must be >= 1.
- H_POL, 0, hsync active level (0 = active-low, 1 = active-high).
- V_POL, 0, vsync active level (0 = active-low, 1 = active-high).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; asynchronous, active-high
- en_in  in  1  pixel enable; counters and outputs advance only on cycles where en_in=1
- sx_out  out  CORDW  horizontal position
- sy_out  out  CORDW  vertical position
- hsync_out  out  1  horizontal sync, level set by H_POL
- vsync_out  out  1  vertical sync, level set by V_POL
- de_out  out  1  data enable; high only inside the active area
- line_out  out  1  high for the single enabled pixel where sx_out=0
- frame_out  out  1  high for the single enabled pixel where sx_out=0 and sy_out=0

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Reset (async assert, sync-released by the upstream reset block):
  - sx_out = H_TOTAL-1, sy_out = V_TOTAL-1 (last pixel of the frame, inside the back porch).
  - de_out = 0, line_out = 0, frame_out = 0.
  - hsync_out = ~H_POL, vsync_out = ~V_POL (both inactive).
- On each rising clk_in with en_in=1:
  - If sx = H_TOTAL-1: sx <= 0, and sy <= (sy = V_TOTAL-1) ? 0 : sy+1.
  - Otherwise sx <= sx+1.
- en_in=0 holds every output at its current value. line_out and frame_out also hold, so a strobe spans exactly one enabled pixel, not one clock.
- Output alignment: all outputs are registered and describe the same pixel. Sync/de/strobe values are computed from the next position, so there is zero skew between sx/sy and the decoded signals.
- Decode, for the pixel at (sx, sy):
  - de = (sx < H_ACTIVE) && (sy < V_ACTIVE).
  - hsync active when H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC.
  - vsync active when V_ACTIVE+V_FP <= sy < V_ACTIVE+V_FP+V_SYNC; vsync changes at sx=0 of the line.
  - line = (sx = 0); frame = (sx = 0 && sy = 0).
- First enabled cycle after reset release yields (0,0) with de=1, line_out=1, frame_out=1.
- Wrap-around: (H_TOTAL-1, V_TOTAL-1) -> (0,0); no extra line or pixel is inserted.
- Reset asserted mid-frame: outputs go to reset values immediately, without waiting for a clock edge.
- Width rule: comparisons are done at CORDW+1 bits so that sums of parameters do not overflow.
- Elaboration-time assertions: reject H_BP=0, V_BP=0, and any CORDW too small for H_TOTAL or V_TOTAL.

Decomposition:
- Package video_pkg holds:
  - a timing struct type (active, fp, sync, bp, pol);
  - preset constants VT_640x480_60 and VT_1280x720_60 (74.25 MHz: 1280/110/40/220, 720/5/5/20, active-high);
  - a helper function that returns the total from a struct.
- One sub-module is natural: axis_counter. It is instantiated twice (horizontal and vertical) and provides the counter, wrap flag, and active/sync decode for one axis. The vertical instance is advanced by the horizontal wrap flag.

Test Plan:
- Defaults, en_in=1, run 2 frames -> exactly 800 clocks per line and 525 lines per frame. hsync_out=0 only for sx 656..751; vsync_out=0 only for sy 490..491. de_out high for 307200 pixels per frame.
- Reset release -> first edge gives sx=0, sy=0, de=1, line_out=1, frame_out=1. frame_out then recurs every 420000 enabled cycles.
- en_in toggled 1-0-0-1 (divide-by-2 and a gap pattern) -> outputs frozen on en_in=0 cycles. Strobes persist exactly one enabled pixel; the sequence equals the en_in=1 run with the frozen cycles removed.
- Reset asserted asynchronously at (300,200), mid-clock -> outputs reach reset values before the next edge. After release, the raster restarts at (0,0).
- Tiny instance (H 4/1/2/1, V 3/1/1/1, H_POL=1, V_POL=1, CORDW=4) -> H_TOTAL=8, V_TOTAL=6. hsync high only at sx 5..6; vsync high only at sy 4; wrap (7,5)->(0,0).
- 720p preset -> H_TOTAL=1650, V_TOTAL=750. Sync signals are active-high; hsync high for sx 1390..1429.
